// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch requester and
// the MEM-stage data requester. Data wins when both want the memory. The
// optional fairness rule lets a waiting fetch through after STARVE_LIMIT
// consecutive data grants.
//
// Configuration macro:
//   ARB_FAIR_EN  defined   -> StarveCnt fairness rule is active
//                undefined -> strict data priority; STARVE_LIMIT has no effect
//
// Ports:
//   Clk, Rst          clock (rising edge) and async active-low reset
//   IFReq/IFAddr      fetch request (read-only) and its address
//   IFRData/IFReady   fetch read data and one-cycle completion pulse
//   DReq/DWrite/DAddr/DWData  data request, write flag, address, write data
//   DRData/DReady     data read data and one-cycle completion pulse
//   MemReq/MemWrite/MemAddr/MemWData  registered request to the memory
//   MemRData/MemAck   memory read data and completion handshake
//   StallIF/StallMEM  combinational pipeline stall requests
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IFReq,
  input  logic [31:0] IFAddr,
  output logic [31:0] IFRData,
  output logic        IFReady,
  input  logic        DReq,
  input  logic        DWrite,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        StallIF,
  output logic        StallMEM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic if_elig;
  logic d_elig;
  logic turnaround;
  logic grant_i;
  logic grant_d;
  logic ack_i;
  logic ack_d;
  logic starve_hit;

`ifdef ARB_FAIR_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CW'(STARVE_LIMIT));

  // Counts data grants that overtook a waiting fetch; saturates at the
  // limit and is cleared whenever the fetch finally gets the memory.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && IFReq && !starve_hit) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end
`else
  // Strict data priority: the fetch never forces its way in. The
  // comparison folds to 0 for any legal limit.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decode. The cycle in which a Ready pulses is a
  // turnaround cycle with no new grant; it keeps grants at least three
  // cycles apart and lets a requester that still holds Req high compete
  // again only once its Ready has dropped.
  always_comb begin
    next_state = state;
    if_elig    = IFReq & ~IFReady;
    d_elig     = DReq & ~DReady;
    turnaround = IFReady | DReady;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!turnaround) begin
          grant_d = d_elig & ~(if_elig & starve_hit);
          grant_i = if_elig & ~grant_d;
        end
        if (grant_d) begin
          next_state = BUSY_D;
        end else if (grant_i) begin
          next_state = BUSY_I;
        end
      end
      BUSY_I: begin
        if (MemAck) begin
          next_state = IDLE;
        end
      end
      BUSY_D: begin
        if (MemAck) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode: stall requests and memory-completion strobes.
  always_comb begin
    StallIF  = IFReq & ~IFReady;
    StallMEM = DReq & ~DReady;
    ack_i    = (state == BUSY_I) & MemAck;
    ack_d    = (state == BUSY_D) & MemAck;
  end

  // Registered memory port and requester return path. The memory request
  // fields are loaded only on a grant so they stay frozen until MemAck.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      MemReq   <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
      IFReady  <= 1'b0;
      DReady   <= 1'b0;
      IFRData  <= '0;
      DRData   <= '0;
    end else begin
      IFReady <= ack_i;
      DReady  <= ack_d;
      if (grant_d) begin
        MemReq   <= 1'b1;
        MemWrite <= DWrite;
        MemAddr  <= DAddr;
        MemWData <= DWData;
      end else if (grant_i) begin
        MemReq   <= 1'b1;
        MemWrite <= 1'b0;
        MemAddr  <= IFAddr;
        MemWData <= '0;
      end else if (ack_i || ack_d) begin
        MemReq <= 1'b0;
      end
      if (ack_i) begin
        IFRData <= MemRData;
      end
      if (ack_d && !MemWrite) begin
        DRData <= MemRData;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Bench for mem_port_arbiter. A behavioural memory answers MemReq after a
// programmable number of cycles. Expected read-back values are queued per
// requester when a request is driven and popped when that requester's Ready
// pulses; every grant seen on the memory port is logged for ordering checks.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        IFReq = 1'b0;
  logic [31:0] IFAddr = '0;
  logic [31:0] IFRData;
  logic        IFReady;
  logic        DReq = 1'b0;
  logic        DWrite = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] DWData = '0;
  logic [31:0] DRData;
  logic        DReady;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData = '0;
  logic        MemAck = 1'b0;
  logic        StallIF;
  logic        StallMEM;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          ack_delay = 0;
  bit          spurious_ack = 1'b0;
  logic [31:0] mem_model [logic [31:0]];
  logic [31:0] if_q [$];
  logic [31:0] d_q [$];
  grant_t      grant_log [$];
  logic [31:0] d_last = '0;
  logic [31:0] if_last = '0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .Clk(Clk), .Rst(Rst),
    .IFReq(IFReq), .IFAddr(IFAddr), .IFRData(IFRData), .IFReady(IFReady),
    .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
    .DRData(DRData), .DReady(DReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemAck(MemAck),
    .StallIF(StallIF), .StallMEM(StallMEM)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acknowledges after ack_delay busy cycles; drives junk on
  // MemRData whenever it is not acknowledging a read.
  initial begin : mem_proc
    int cnt;
    cnt = 0;
    forever begin
      @(negedge Clk);
      MemAck   = 1'b0;
      MemRData = 32'hEEEE_EEEE;
      if (Rst && MemReq) begin
        if (cnt == ack_delay) begin
          MemAck = 1'b1;
          if (MemWrite) mem_model[MemAddr] = MemWData;
          else          MemRData = rd(MemAddr);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        if (spurious_ack) begin
          MemAck   = 1'b1;
          MemRData = 32'h0BAD_0BAD;
        end
      end
    end
  end

  // Monitor: logs grants, checks request stability while waiting, and pops
  // the scoreboard on every Ready pulse.
  initial begin : monitor
    logic        prev_req;
    grant_t      cur;
    logic [31:0] exp_v;
    prev_req = 1'b0;
    cur      = '0;
    forever begin
      @(negedge Clk);
      if (MemReq && !prev_req) begin
        cur.wr = MemWrite; cur.addr = MemAddr; cur.wdata = MemWData;
        grant_log.push_back(cur);
      end else if (MemReq && prev_req) begin
        n_cmp++;
        if ({MemWrite, MemAddr, MemWData} !== cur) begin
          n_fail++;
          $display("[TB] FAIL mem_hold: got %h required %h", {MemWrite, MemAddr, MemWData}, cur);
        end
      end
      if (IFReady === 1'b1) begin
        n_cmp++;
        if (if_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL if_ready_unexpected: got IFReady=1 required no pulse");
        end else begin
          exp_v = if_q.pop_front();
          if (IFRData !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL if_rdata: got %h required %h", IFRData, exp_v);
          end
        end
      end
      if (DReady === 1'b1) begin
        n_cmp++;
        if (d_q.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL d_ready_unexpected: got DReady=1 required no pulse");
        end else begin
          exp_v = d_q.pop_front();
          if (DRData !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL d_rdata: got %h required %h", DRData, exp_v);
          end
        end
      end
      prev_req = MemReq;
    end
  end

  task automatic test_reset();
    Rst = 1'b0;
    IFReq = 1'b1;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if ({MemReq, MemWrite, IFReady, DReady} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b required 0000", {MemReq, MemWrite, IFReady, DReady});
    end
    n_cmp++;
    if ({MemAddr, MemWData, IFRData, DRData} !== 128'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got %h required 0", {MemAddr, MemWData, IFRData, DRData});
    end
    n_cmp++;
    if (StallIF !== 1'b1 || StallMEM !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_stall: got %b%b required 10", StallIF, StallMEM);
    end
    IFReq = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (MemReq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got MemReq=%b required 0", MemReq);
    end
  endtask

  task automatic test_fetch();
    mem_model[32'h40] = 32'h8C01_0004;
    IFAddr = 32'h40;
    IFReq  = 1'b1;
    if_q.push_back(rd(32'h40));
    if_last = rd(32'h40);
    #1;
    n_cmp++;
    if (StallIF !== 1'b1 || MemReq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch_req: got StallIF=%b MemReq=%b required 1 0", StallIF, MemReq);
    end
    @(negedge Clk);
    n_cmp++;
    if ({MemReq, MemWrite, MemAddr, IFReady, StallIF} !== {1'b1, 1'b0, 32'h40, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL fetch_busy: got req=%b wr=%b addr=%h rdy=%b stall=%b required 1 0 40 0 1",
               MemReq, MemWrite, MemAddr, IFReady, StallIF);
    end
    @(negedge Clk);
    n_cmp++;
    if (IFReady !== 1'b1 || IFRData !== 32'h8C01_0004 || StallIF !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch_done: got rdy=%b data=%h stall=%b required 1 8c010004 0",
               IFReady, IFRData, StallIF);
    end
    IFReq = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (IFReady !== 1'b0 || MemReq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL fetch_after: got rdy=%b req=%b required 0 0", IFReady, MemReq);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    base   = grant_log.size();
    IFAddr = 32'h44;
    IFReq  = 1'b1;
    DAddr  = 32'h100;
    DWData = 32'hDEAD_BEEF;
    DWrite = 1'b1;
    DReq   = 1'b1;
    d_q.push_back(d_last);
    if_q.push_back(rd(32'h44));
    if_last = rd(32'h44);
    for (int i = 0; i < 30 && (IFReq || DReq); i++) begin
      @(negedge Clk);
      if (IFReady) IFReq = 1'b0;
      if (DReady) DReq = 1'b0;
    end
    n_cmp++;
    if (IFReq || DReq) begin
      n_fail++;
      $display("[TB] FAIL simul_timeout: got pending IF=%b D=%b required both done", IFReq, DReq);
      IFReq = 1'b0;
      DReq = 1'b0;
    end
    DWrite = 1'b0;
    n_cmp++;
    if (grant_log.size() - base != 2) begin
      n_fail++;
      $display("[TB] FAIL simul_grants: got %0d required 2", grant_log.size() - base);
    end else begin
      n_cmp++;
      if (grant_log[base] !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin
        n_fail++;
        $display("[TB] FAIL simul_first: got %h required data write", grant_log[base]);
      end
      n_cmp++;
      if (grant_log[base+1].wr !== 1'b0 || grant_log[base+1].addr !== 32'h44) begin
        n_fail++;
        $display("[TB] FAIL simul_second: got %h required fetch 44", grant_log[base+1]);
      end
    end
    n_cmp++;
    if (DRData !== d_last || rd(32'h100) !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("[TB] FAIL simul_write: got DRData=%h mem=%h required %h deadbeef",
               DRData, rd(32'h100), d_last);
    end
  endtask

  task automatic test_starvation();
    int         base;
    logic [9:0] seen;
    logic [9:0] exp_pat;
`ifdef ARB_FAIR_EN
    exp_pat = 10'b10_0001_0000;
`else
    exp_pat = 10'b0;
`endif
    base = grant_log.size();
    for (int k = 0; k < 10; k++) begin
      if (exp_pat[k]) begin
        if_q.push_back(rd(32'h80));
        if_last = rd(32'h80);
      end else begin
        d_q.push_back(rd(32'h200));
        d_last = rd(32'h200);
      end
    end
    IFAddr = 32'h80;
    DAddr  = 32'h200;
    DWrite = 1'b0;
    IFReq  = 1'b1;
    DReq   = 1'b1;
    for (int i = 0; i < 100 && grant_log.size() - base < 10; i++) @(negedge Clk);
    IFReq = 1'b0;
    DReq  = 1'b0;
    repeat (6) @(negedge Clk);
    seen = '0;
    for (int k = 0; k < 10 && base + k < grant_log.size(); k++)
      seen[k] = (grant_log[base+k].addr == 32'h80);
    n_cmp++;
    if (grant_log.size() - base != 10 || seen !== exp_pat) begin
      n_fail++;
      $display("[TB] FAIL starve_pattern: got %0d grants fetch-map %b required 10 grants %b",
               grant_log.size() - base, seen, exp_pat);
    end
    n_cmp++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL starve_drain: got if_q=%0d d_q=%0d required 0 0", if_q.size(), d_q.size());
    end
  endtask

  task automatic test_mem_wait();
    int base;
    base = grant_log.size();
    ack_delay = 5;
    mem_model[32'h300] = 32'h1234_5678;
    DAddr = 32'h300;
    DWrite = 1'b0;
    DReq = 1'b1;
    d_q.push_back(32'h1234_5678);
    d_last = 32'h1234_5678;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      n_cmp++;
      if (MemReq !== 1'b1 || MemAddr !== 32'h300 || DReady !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL wait_hold[%0d]: got req=%b addr=%h rdy=%b required 1 300 0",
                 i, MemReq, MemAddr, DReady);
      end
    end
    @(negedge Clk);
    n_cmp++;
    if (DReady !== 1'b1 || MemReq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wait_done: got rdy=%b req=%b required 1 0", DReady, MemReq);
    end
    DReq = 1'b0;
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (grant_log.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL wait_grants: got %0d required 1", grant_log.size() - base);
    end
    ack_delay = 0;
  endtask

  task automatic test_reset_midop();
    int base;
    base = grant_log.size();
    ack_delay = 10;
    DAddr = 32'h400;
    DWrite = 1'b0;
    DReq = 1'b1;
    repeat (2) @(negedge Clk);
    #2;
    Rst = 1'b0;
    #1;
    n_cmp++;
    if (MemReq !== 1'b0 || DReady !== 1'b0 || MemAddr !== 32'h0 || DRData !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL midop_async: got req=%b rdy=%b addr=%h rdata=%h required 0 0 0 0",
               MemReq, DReady, MemAddr, DRData);
    end
    DReq = 1'b0;
    d_last = '0;
    if_last = '0;
    @(negedge Clk);
    Rst = 1'b1;
    repeat (15) @(negedge Clk);
    n_cmp++;
    if (MemReq !== 1'b0 || grant_log.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL midop_idle: got req=%b grants=%0d required 0 1", MemReq, grant_log.size() - base);
    end
    ack_delay = 0;
  endtask

  task automatic test_spurious_ack();
    spurious_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      n_cmp++;
      if ({MemReq, IFReady, DReady} !== 3'b0 || IFRData !== if_last || DRData !== d_last) begin
        n_fail++;
        $display("[TB] FAIL idle_ack[%0d]: got req/rdy=%b if=%h d=%h required 000 %h %h",
                 i, {MemReq, IFReady, DReady}, IFRData, DRData, if_last, d_last);
      end
    end
    spurious_ack = 1'b0;
  endtask

  task automatic test_aborted();
    int base;
    int pulses;
    base = grant_log.size();
    ack_delay = 2;
    mem_model[32'h500] = 32'hCAFE_F00D;
    DAddr = 32'h500;
    DWrite = 1'b0;
    DReq = 1'b1;
    d_q.push_back(32'hCAFE_F00D);
    d_last = 32'hCAFE_F00D;
    @(negedge Clk);
    @(negedge Clk);
    DReq = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (DReady === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 1 || grant_log.size() - base != 1) begin
      n_fail++;
      $display("[TB] FAIL aborted: got pulses=%0d grants=%0d required 1 1", pulses, grant_log.size() - base);
    end
    n_cmp++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL final_drain: got if_q=%0d d_q=%0d required 0 0", if_q.size(), d_q.size());
    end
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_mem_wait();
    test_reset_midop();
    test_spurious_ack();
    test_aborted();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
